// File: rtl/if_fetch_unit_if.sv
// Fetch-to-decode handshake: head entry of the fetch queue offered to ID.
interface if_fetch_unit_if #(
  parameter int NB_PC          = 32,
  parameter int NB_INSTRUCTION = 32
);
  logic                      o_valid;
  logic                      i_ready;
  logic [NB_INSTRUCTION-1:0] o_instruction;
  logic [NB_PC-1:0]          o_pc;
  logic [NB_PC-1:0]          o_pc_next;

  modport master (
    output o_valid,
    output o_instruction,
    output o_pc,
    output o_pc_next,
    input  i_ready
  );

  modport slave (
    input  o_valid,
    input  o_instruction,
    input  o_pc,
    input  o_pc_next,
    output i_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC with prioritised redirect, debug-loadable byte memory,
// one-cycle synchronous read and a flushable fetch queue toward decode.
module if_fetch_unit #(
  parameter int                        NB_PC          = 32,
  parameter int                        NB_INSTRUCTION = 32,
  parameter int                        NB_MEM_WIDTH   = 8,
  parameter int                        NB_IM_ADDR     = 8,
  parameter int                        FQ_DEPTH       = 4,
  parameter int                        PC_STEP        = 4,
  parameter logic [NB_PC-1:0]          RESET_PC       = '0,
  parameter logic [NB_INSTRUCTION-1:0] HALT_WORD      = 32'hFFFFFFFF
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_run,
  input  logic                    i_load_enable,
  input  logic [NB_IM_ADDR-1:0]   i_load_addr,
  input  logic [NB_MEM_WIDTH-1:0] i_load_data,
  input  logic                    i_redirect_jr,
  input  logic                    i_redirect_j,
  input  logic                    i_redirect_branch,
  input  logic [NB_PC-1:0]        i_r31_data,
  input  logic [NB_PC-1:0]        i_jump_addr,
  input  logic [NB_PC-1:0]        i_branch_addr,
  if_fetch_unit_if.master         dec_if,
  output logic                    o_halted,
  output logic [NB_PC-1:0]        o_fetch_pc
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NB_MEM_WIDTH-1:0]   mem_q [0:(1<<NB_IM_ADDR)-1];

  logic [NB_PC-1:0]          pc_q, pc_d;
  logic                      inflight_q, inflight_d;
  logic [NB_PC-1:0]          inflight_pc_q, inflight_pc_d;
  logic [NB_INSTRUCTION-1:0] rdata_q, rdata_d;
  logic                      halted_q, halted_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [NB_PC-1:0]          fq_pc_q [FQ_DEPTH];
  logic [NB_PC-1:0]          fq_pc_d [FQ_DEPTH];
  logic [NB_INSTRUCTION-1:0] fq_instr_q [FQ_DEPTH];
  logic [NB_INSTRUCTION-1:0] fq_instr_d [FQ_DEPTH];

  logic                      redirect;
  logic [NB_PC-1:0]          target;
  logic                      head_valid;
  logic                      pop;
  logic                      halt_fill;
  logic [CNT_W-1:0]          occ;
  logic                      issue;
  logic [NB_IM_ADDR-3:0]     word_addr;
  logic [NB_INSTRUCTION-1:0] rd_word;
  logic                      unused_pc_bits;

  assign word_addr      = pc_q[NB_IM_ADDR-1:2];
  assign rd_word        = {mem_q[{word_addr, 2'd0}], mem_q[{word_addr, 2'd1}],
                           mem_q[{word_addr, 2'd2}], mem_q[{word_addr, 2'd3}]};
  assign unused_pc_bits = ^{pc_q[NB_PC-1:NB_IM_ADDR], pc_q[1:0]};

  always_comb begin
    redirect   = i_redirect_jr | i_redirect_j | i_redirect_branch;
    target     = i_redirect_jr ? i_r31_data :
                 i_redirect_j  ? i_jump_addr : i_branch_addr;
    head_valid = (count_q != '0);
    pop        = head_valid & dec_if.i_ready;
    // A halt word still in flight must block issue in the same cycle it returns
    halt_fill  = inflight_q && (rdata_q == HALT_WORD);
    occ        = count_q + CNT_W'(inflight_q) - CNT_W'(pop);
    issue      = i_run & ~i_load_enable & ~halted_q & ~halt_fill & ~redirect &
                 (occ < CNT_W'(FQ_DEPTH));
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    rdata_d       = rdata_q;
    halted_d      = halted_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    fq_pc_d       = fq_pc_q;
    fq_instr_d    = fq_instr_q;

    if (redirect) begin
      pc_d       = target;
      inflight_d = 1'b0;
      halted_d   = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (inflight_q) begin
        fq_pc_d[wr_ptr_q]    = inflight_pc_q;
        fq_instr_d[wr_ptr_q] = rdata_q;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d    = occ;
      halted_d   = halted_q | halt_fill;
      inflight_d = issue;
      if (issue) begin
        pc_d          = pc_q + NB_PC'(PC_STEP);
        inflight_pc_d = pc_q;
        rdata_d       = rd_word;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rdata_q       <= '0;
      halted_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rdata_q       <= rdata_d;
      halted_q      <= halted_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Queue payload needs no reset: visibility is governed by count_q alone
  always_ff @(posedge i_clock) begin
    fq_pc_q    <= fq_pc_d;
    fq_instr_q <= fq_instr_d;
  end

  // Memory survives reset, but a load coinciding with reset is dropped
  always_ff @(posedge i_clock) begin
    if (!i_reset && i_load_enable) begin
      mem_q[i_load_addr] <= i_load_data;
    end
  end

  assign dec_if.o_valid       = head_valid;
  assign dec_if.o_instruction = head_valid ? fq_instr_q[rd_ptr_q] : '0;
  assign dec_if.o_pc          = head_valid ? fq_pc_q[rd_ptr_q] : '0;
  assign dec_if.o_pc_next     = head_valid ? fq_pc_q[rd_ptr_q] + NB_PC'(PC_STEP) : '0;
  assign o_halted             = halted_q;
  assign o_fetch_pc           = pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: latency, back-pressure, redirects, halt, load stall, wrap, reset.
module tb_if_fetch_unit;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_run;
  logic        i_load_enable;
  logic [7:0]  i_load_addr;
  logic [7:0]  i_load_data;
  logic        i_redirect_jr;
  logic        i_redirect_j;
  logic        i_redirect_branch;
  logic [31:0] i_r31_data;
  logic [31:0] i_jump_addr;
  logic [31:0] i_branch_addr;
  logic        o_halted;
  logic [31:0] o_fetch_pc;

  int checks = 0;
  int errors = 0;

  always #5 i_clock = ~i_clock;

  if_fetch_unit_if #(.NB_PC(32), .NB_INSTRUCTION(32)) dec_if ();

  if_fetch_unit dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_run            (i_run),
    .i_load_enable    (i_load_enable),
    .i_load_addr      (i_load_addr),
    .i_load_data      (i_load_data),
    .i_redirect_jr    (i_redirect_jr),
    .i_redirect_j     (i_redirect_j),
    .i_redirect_branch(i_redirect_branch),
    .i_r31_data       (i_r31_data),
    .i_jump_addr      (i_jump_addr),
    .i_branch_addr    (i_branch_addr),
    .dec_if           (dec_if),
    .o_halted         (o_halted),
    .o_fetch_pc       (o_fetch_pc)
  );

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      i_load_enable = 1'b1;
      i_load_addr   = a + 8'(k);
      i_load_data   = w[31-8*k -: 8];
      tick();
    end
    i_load_enable = 1'b0;
  endtask

  task automatic pulse_branch(input logic [31:0] t);
    i_redirect_branch = 1'b1;
    i_branch_addr     = t;
    tick();
    i_redirect_branch = 1'b0;
  endtask

  logic [31:0] drain_exp [5];
  logic [39:0] stall_bytes;

  initial begin
    i_reset = 1'b1; i_run = 1'b0; i_load_enable = 1'b0;
    i_load_addr = '0; i_load_data = '0;
    i_redirect_jr = 1'b0; i_redirect_j = 1'b0; i_redirect_branch = 1'b0;
    i_r31_data = '0; i_jump_addr = '0; i_branch_addr = '0;
    dec_if.i_ready = 1'b0;
    drain_exp = '{32'h01020304, 32'h0A0B0C0D, 32'h11111111, 32'h22222222, 32'h33333333};
    stall_bytes = 40'hDEADBEEF77;

    tick(); tick();
    chk("rst_valid",    32'(dec_if.o_valid), 32'd0);
    chk("rst_halted",   32'(o_halted), 32'd0);
    chk("rst_instr",    dec_if.o_instruction, 32'd0);
    chk("rst_pc",       dec_if.o_pc, 32'd0);
    chk("rst_pc_next",  dec_if.o_pc_next, 32'd0);
    chk("rst_fetch_pc", o_fetch_pc, 32'd0);

    i_reset = 1'b0;
    load_word(8'h00, 32'h01020304);
    load_word(8'h04, 32'h0A0B0C0D);
    load_word(8'h08, 32'h11111111);
    load_word(8'h0C, 32'h22222222);
    load_word(8'h10, 32'h33333333);
    load_word(8'h20, 32'h20202020);
    load_word(8'h24, 32'h24242424);
    load_word(8'h28, 32'h28282828);
    load_word(8'h2C, 32'h2C2C2C2C);
    load_word(8'h30, 32'h30303030);
    load_word(8'h40, 32'h40404040);
    load_word(8'h80, 32'h80808080);
    load_word(8'hC0, 32'hC0C0C0C0);

    // first fetch after reset release
    i_reset = 1'b1; i_run = 1'b1; dec_if.i_ready = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("t1_valid_c0", 32'(dec_if.o_valid), 32'd0);
    chk("t1_fpc_c0",   o_fetch_pc, 32'd0);
    tick();
    chk("t1_valid_c1", 32'(dec_if.o_valid), 32'd0);
    tick();
    chk("t1_valid_c2", 32'(dec_if.o_valid), 32'd1);
    chk("t1_instr_c2", dec_if.o_instruction, 32'h01020304);
    chk("t1_pc_c2",    dec_if.o_pc, 32'h0);
    chk("t1_pcn_c2",   dec_if.o_pc_next, 32'h4);
    tick();
    chk("t1_instr_c3", dec_if.o_instruction, 32'h0A0B0C0D);
    chk("t1_pc_c3",    dec_if.o_pc, 32'h4);
    chk("t1_fpc_c3",   o_fetch_pc, 32'hC);

    // back-pressure saturation and ordered drain
    i_reset = 1'b1; dec_if.i_ready = 1'b0;
    tick();
    i_reset = 1'b0;
    repeat (10) tick();
    chk("bp_valid", 32'(dec_if.o_valid), 32'd1);
    chk("bp_head",  dec_if.o_pc, 32'h0);
    chk("bp_fpc",   o_fetch_pc, 32'h10);
    dec_if.i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain_pc%0d", k),    dec_if.o_pc, 32'(4*k));
      chk($sformatf("drain_instr%0d", k), dec_if.o_instruction, drain_exp[k]);
      tick();
    end

    // simultaneous redirects: jr wins
    i_redirect_jr = 1'b1; i_r31_data = 32'hC0;
    i_redirect_j = 1'b1; i_jump_addr = 32'h80;
    i_redirect_branch = 1'b1; i_branch_addr = 32'h40;
    tick();
    i_redirect_jr = 1'b0; i_redirect_j = 1'b0; i_redirect_branch = 1'b0;
    chk("rd_valid_r1", 32'(dec_if.o_valid), 32'd0);
    chk("rd_fpc_r1",   o_fetch_pc, 32'hC0);
    tick();
    chk("rd_valid_r2", 32'(dec_if.o_valid), 32'd0);
    chk("rd_fpc_r2",   o_fetch_pc, 32'hC4);
    tick();
    chk("rd_valid_r3", 32'(dec_if.o_valid), 32'd1);
    chk("rd_pc_r3",    dec_if.o_pc, 32'hC0);
    chk("rd_instr_r3", dec_if.o_instruction, 32'hC0C0C0C0);
    chk("rd_pcn_r3",   dec_if.o_pc_next, 32'hC4);

    // load stall mid-stream, overwriting word 0x30
    pulse_branch(32'h20);
    tick(); tick();
    chk("ls_head", dec_if.o_pc, 32'h20);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ls_fpc_hold%0d", k), o_fetch_pc, 32'h28);
      i_load_enable = 1'b1;
      i_load_addr   = 8'h30 + 8'(k);
      i_load_data   = stall_bytes[39-8*k -: 8];
      tick();
    end
    i_load_enable = 1'b0;
    chk("ls_fpc_drop", o_fetch_pc, 32'h28);
    tick();
    chk("ls_fpc_resume", o_fetch_pc, 32'h2C);
    tick();
    chk("ls_pc_28", dec_if.o_pc, 32'h28);
    tick();
    chk("ls_pc_2c", dec_if.o_pc, 32'h2C);
    tick();
    chk("ls_pc_30",    dec_if.o_pc, 32'h30);
    chk("ls_instr_30", dec_if.o_instruction, 32'hDEADBEEF);

    // halt word at 0x10
    i_run = 1'b0;
    tick();
    load_word(8'h10, 32'hFFFFFFFF);
    i_run = 1'b1;
    pulse_branch(32'h0);
    tick(); tick();
    chk("h_pc0", dec_if.o_pc, 32'h0);
    tick(); tick(); tick();
    chk("h_halt_early", 32'(o_halted), 32'd0);
    chk("h_pc_c",       dec_if.o_pc, 32'hC);
    tick();
    chk("h_pc_10",    dec_if.o_pc, 32'h10);
    chk("h_instr_10", dec_if.o_instruction, 32'hFFFFFFFF);
    chk("h_halted",   32'(o_halted), 32'd1);
    chk("h_fpc",      o_fetch_pc, 32'h14);
    repeat (3) tick();
    chk("h_valid_after", 32'(dec_if.o_valid), 32'd0);
    chk("h_halted_hold", 32'(o_halted), 32'd1);
    chk("h_fpc_hold",    o_fetch_pc, 32'h14);
    pulse_branch(32'h0);
    chk("h_cleared", 32'(o_halted), 32'd0);
    tick(); tick();
    chk("h_resume_valid", 32'(dec_if.o_valid), 32'd1);
    chk("h_resume_pc",    dec_if.o_pc, 32'h0);

    // PC wrap past 2^NB_IM_ADDR bytes
    pulse_branch(32'h100);
    tick(); tick();
    chk("w_pc",    dec_if.o_pc, 32'h100);
    chk("w_instr", dec_if.o_instruction, 32'h01020304);
    chk("w_pcn",   dec_if.o_pc_next, 32'h104);
    dec_if.i_ready = 1'b0;
    repeat (8) tick();
    chk("w_full_fpc", o_fetch_pc, 32'h110);
    chk("w_full_pc",  dec_if.o_pc, 32'h100);

    // reset with full queue and a pending load byte
    i_reset = 1'b1; i_load_enable = 1'b1; i_load_addr = 8'h00; i_load_data = 8'hEE;
    tick();
    i_reset = 1'b0; i_load_enable = 1'b0; dec_if.i_ready = 1'b1;
    chk("rr_valid", 32'(dec_if.o_valid), 32'd0);
    chk("rr_fpc",   o_fetch_pc, 32'h0);
    tick(); tick();
    chk("rr_pc",    dec_if.o_pc, 32'h0);
    chk("rr_instr", dec_if.o_instruction, 32'h01020304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Parametrised instruction-fetch stage: PC register with prioritised redirect, a debug-loadable byte-wide instruction memory, and a decoupled fetch queue feeding decode through a valid/ready handshake. Sits between the debug unit (program loading) and the ID stage, and replaces the single-shot fetch path. It adds:
- back-pressure buffering
- redirect flushing
- halt-word detection

## Interface
Parameters:
- NB_PC, 32, PC width
- NB_INSTRUCTION, 32, instruction width; must be 4 × NB_MEM_WIDTH
- NB_MEM_WIDTH, 8, memory byte width
- NB_IM_ADDR, 8, byte-address width of instruction memory (2^NB_IM_ADDR bytes)
- FQ_DEPTH, 4, fetch-queue entries; power of 2, ≥2
- PC_STEP, 4, sequential PC increment
- RESET_PC, 0, PC after reset
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch

Ports:
- i_clock  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_run  in  1  fetch enable; 0 suspends issue (queue still drains)
- i_load_enable  in  1  debug byte write to instruction memory this cycle
- i_load_addr  in  NB_IM_ADDR  debug byte address
- i_load_data  in  NB_MEM_WIDTH  debug byte data
- i_redirect_jr  in  1  JR/JALR redirect, highest priority
- i_redirect_j  in  1  J/JAL redirect
- i_redirect_branch  in  1  taken-branch redirect, lowest priority
- i_r31_data  in  NB_PC  JR/JALR target
- i_jump_addr  in  NB_PC  J/JAL target
- i_branch_addr  in  NB_PC  branch target
- i_ready  in  1  decode accepts head entry
- o_valid  out  1  head entry valid
- o_instruction  out  NB_INSTRUCTION  head instruction
- o_pc  out  NB_PC  PC of head instruction
- o_pc_next  out  NB_PC  o_pc + PC_STEP
- o_halted  out  1  halt word fetched; issue stopped
- o_fetch_pc  out  NB_PC  current PC register, for the debug unit

## Operation
- **Memory:** byte array, one write port (debug) and one synchronous word-read port.
  - Read word = bytes [a, a+1, a+2, a+3], big-endian: byte a in MSBs.
  - Read address a = {pc[NB_IM_ADDR-1:2], 2'b00]}. PC bits above NB_IM_ADDR are ignored (wrap); low two bits are ignored (aligned down).
- **Issue:** one read per cycle when all of the following hold:
  - i_run = 1
  - i_load_enable = 0
  - o_halted = 0
  - no redirect this cycle
  - queue occupancy + in-flight reads − pop this cycle < FQ_DEPTH

  On issue, PC ← PC + PC_STEP and the in-flight tag records the issued PC.
- **Fill:** the in-flight read returns the next cycle and is written to the queue as {pc, instruction}. If the instruction equals HALT_WORD, it is enqueued normally, o_halted sets, and further issue is blocked.
- **Pop:** occurs when o_valid & i_ready. While o_valid = 1 and no redirect occurs, the outputs hold steady until popped.
- **Redirect:** priority jr > j > branch. On any redirect:
  - PC ← selected target
  - queue flushed
  - in-flight read squashed (not enqueued)
  - o_halted cleared
  - a pop in the same cycle is discarded
- **Load vs fetch:** load has priority for the memory port; issue stalls while i_load_enable = 1. A redirect during load still updates PC.
- **Reset:** resets PC, queue and in-flight state only. Memory contents are preserved across reset.

## Timing
- **Reset values:**
  - PC = RESET_PC
  - queue empty, no in-flight read
  - o_valid = 0, o_halted = 0
  - o_instruction = 0, o_pc = 0, o_pc_next = 0 while empty
  - o_fetch_pc = RESET_PC
- **Issue → valid:** issue in cycle t, enqueue at end of t+1, o_valid = 1 in cycle t+2.
- **Throughput:** with i_ready held at 1, one instruction per cycle in steady state.
- **After reset release:** first issue in the first cycle with i_reset = 0; o_valid rises 2 cycles later.
- **Redirect in cycle t:**
  - o_valid = 0 from t+1
  - target issued in t+1
  - target instruction presented in t+3
- **Full queue:** occupancy never exceeds FQ_DEPTH. An in-flight read always has a reserved slot, so returned data is never dropped.
- **Empty queue:** o_valid = 0; i_ready is ignored.
- **i_reset during load, redirect or a full queue:** reset wins. The queue is empty next cycle and the pending load byte is not written.

## Test plan
- Load 0x01020304 at bytes 0..3 and 0x0A0B0C0D at 4..7, reset, i_run = 1, i_ready = 1 → o_valid rises 2 cycles after reset release with o_instruction = 0x01020304, o_pc = 0, o_pc_next = 4; the next cycle gives 0x0A0B0C0D, o_pc = 4.
- i_ready = 0 for 10 cycles → occupancy saturates at FQ_DEPTH = 4 with PCs 0, 4, 8, 12 and o_fetch_pc = 16; raising i_ready drains them in order with no loss or duplication.
- Redirect collision: assert i_redirect_branch (0x40), i_redirect_j (0x80) and i_redirect_jr (0xC0) in one cycle → queue flushed; the next o_valid shows o_pc = 0xC0 exactly 3 cycles later.
- Halt word: place HALT_WORD at 0x10 → it is delivered with o_pc = 0x10 and o_halted = 1; no PC > 0x10 is issued. A later redirect to 0 clears o_halted and fetch resumes.
- Load stall: hold i_load_enable = 1 for 5 cycles mid-stream → no issue and o_fetch_pc frozen; fetch resumes the cycle load drops. Bytes written during the stall are visible on subsequent reads.
- Wraparound and reset: a redirect to 0x100 with NB_IM_ADDR = 8 fetches byte address 0. Asserting i_reset with a full queue → o_valid = 0 next cycle and PC = RESET_PC.
